// File: rtl/prefetch_rom.sv
// Burst-prefetching ROM: a request streams len+1 consecutive words through a
// LATENCY-deep read pipeline into a small credit-controlled response FIFO.
module prefetch_rom #(
  parameter int    DATA_W    = 24,
  parameter int    ADDR_W    = 5,
  parameter int    DEPTH     = 32,
  parameter int    LATENCY   = 1,
  parameter int    LEN_W     = 3,
  parameter string INIT_FILE = "rom.txt"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err
);

  localparam int              FIFO_D   = LATENCY + 1;
  localparam logic [2:0]      FIFO_D_L = 3'(FIFO_D);
  localparam logic [1:0]      LAST_PTR = 2'(FIFO_D - 1);
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  cnt_r;

  logic              accept, active, credit, issue, issue_last, issue_err;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  cur_cnt;
  logic [DATA_W-1:0] img_word, issue_data;

  logic              rd_valid, rd_last, rd_err;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        pipe_count, fifo_count;

  logic [DATA_W+1:0] fifo_mem [0:3];
  logic [1:0]        wr_ptr, rd_ptr;
  logic              push, pop;

  // The accepting cycle already issues its first read, so the address and
  // count come straight from the request port in that cycle.
  assign accept     = req_valid && req_ready;
  assign active     = accept || (state == BURST);
  assign cur_addr   = accept ? req_addr : addr_r;
  assign cur_cnt    = accept ? req_len : cnt_r;
  assign credit     = (fifo_count + pipe_count) < FIFO_D_L;
  assign issue      = active && credit;
  assign issue_last = (cur_cnt == '0);
  assign issue_err  = ({1'b0, cur_addr} >= DEPTH_L);
  assign issue_data = issue_err ? '0 : img_word;

  // ROM image: every byte lane holds the word address.
  always_comb begin
    img_word = '0;
    for (int k = 0; k < DATA_W / 8; k++) img_word[k*8 +: 8] = 8'(cur_addr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      addr_r    <= '0;
      cnt_r     <= '0;
    end else if (active) begin
      if (issue && issue_last) begin
        state     <= IDLE;
        req_ready <= 1'b1;
      end else begin
        state     <= BURST;
        req_ready <= 1'b0;
        addr_r    <= issue ? cur_addr + 1'b1 : cur_addr;
        cnt_r     <= issue ? cur_cnt - 1'b1 : cur_cnt;
      end
    end else begin
      state     <= IDLE;
      req_ready <= 1'b1;
    end
  end

  // With LATENCY 1 the read lands in the FIFO at the issuing edge; LATENCY 2
  // adds one register stage whose occupancy counts against the FIFO credit.
  if (LATENCY == 1) begin : g_lat1
    assign rd_valid   = issue;
    assign rd_data    = issue_data;
    assign rd_last    = issue_last;
    assign rd_err     = issue_err;
    assign pipe_count = 3'd0;
  end else begin : g_lat2
    logic              p_valid, p_last, p_err;
    logic [DATA_W-1:0] p_data;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_valid <= 1'b0;
        p_last  <= 1'b0;
        p_err   <= 1'b0;
        p_data  <= '0;
      end else begin
        p_valid <= issue;
        if (issue) begin
          p_last <= issue_last;
          p_err  <= issue_err;
          p_data <= issue_data;
        end
      end
    end
    assign rd_valid   = p_valid;
    assign rd_data    = p_data;
    assign rd_last    = p_last;
    assign rd_err     = p_err;
    assign pipe_count = {2'b00, p_valid};
  end

  function automatic logic [1:0] bump(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  assign push = rd_valid;
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {rd_err, rd_last, rd_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Outputs are forced to zero when empty so reset and idle both show zeros.
  assign rsp_valid = (fifo_count != 3'd0);
  assign {rsp_err, rsp_last, rsp_data} = rsp_valid ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_prefetch_rom.sv
// Directed bench for prefetch_rom: instance a is DEPTH=30/LATENCY=1, instance b is
// DEPTH=32/LATENCY=2; both share the request and rsp_ready stimulus.
module tb_prefetch_rom;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, rsp_ready;
  logic [4:0]  req_addr;
  logic [2:0]  req_len;

  logic        a_req_ready, a_rsp_valid, a_rsp_last, a_rsp_err;
  logic [23:0] a_rsp_data;
  logic        b_req_ready, b_rsp_valid, b_rsp_last, b_rsp_err;
  logic [23:0] b_rsp_data;

  int checks;
  int errors;

  always #5 clk = ~clk;

  prefetch_rom #(.DATA_W(24), .ADDR_W(5), .DEPTH(30), .LATENCY(1), .LEN_W(3), .INIT_FILE("")) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_addr(req_addr), .req_len(req_len), .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(a_rsp_data), .rsp_last(a_rsp_last), .rsp_err(a_rsp_err)
  );

  prefetch_rom #(.DATA_W(24), .ADDR_W(5), .DEPTH(32), .LATENCY(2), .LEN_W(3), .INIT_FILE("")) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_addr(req_addr), .req_len(req_len), .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(b_rsp_data), .rsp_last(b_rsp_last), .rsp_err(b_rsp_err)
  );

  // Image word i = {3{3'b0, i}}
  function automatic logic [23:0] exp_word(input int i);
    logic [7:0] b;
    b = 8'(i % 32);
    return {b, b, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) step();
  endtask

  task automatic issue_req(input logic [4:0] addr, input logic [2:0] len);
    req_addr  = addr;
    req_len   = len;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if ({a_req_ready, a_rsp_valid, a_rsp_last, a_rsp_err, a_rsp_data} !== 28'h0) begin errors++; $display("[TB] FAIL reset_a_outputs: got %h expected %h", {a_req_ready, a_rsp_valid, a_rsp_last, a_rsp_err, a_rsp_data}, 28'h0); end
    checks++; if ({b_req_ready, b_rsp_valid, b_rsp_last, b_rsp_err, b_rsp_data} !== 28'h0) begin errors++; $display("[TB] FAIL reset_b_outputs: got %h expected %h", {b_req_ready, b_rsp_valid, b_rsp_last, b_rsp_err, b_rsp_data}, 28'h0); end
    rst_n = 1'b1;
    step();
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_a_ready: got %b expected 1", a_req_ready); end
    checks++; if (b_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_b_ready: got %b expected 1", b_req_ready); end
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_a_valid: got %b expected 0", a_rsp_valid); end
  endtask

  task automatic test_single();
    drain();
    issue_req(5'd3, 3'd0);
    checks++; if ({a_rsp_valid, a_rsp_last, a_rsp_err, a_rsp_data} !== {3'b110, exp_word(3)}) begin errors++; $display("[TB] FAIL single_a_word: got %h expected %h", {a_rsp_valid, a_rsp_last, a_rsp_err, a_rsp_data}, {3'b110, exp_word(3)}); end
    checks++; if (b_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_b_early: got %b expected 0", b_rsp_valid); end
    step();
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_a_once: got %b expected 0", a_rsp_valid); end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_a_ready: got %b expected 1", a_req_ready); end
    checks++; if ({b_rsp_valid, b_rsp_last, b_rsp_err, b_rsp_data} !== {3'b110, exp_word(3)}) begin errors++; $display("[TB] FAIL single_b_word: got %h expected %h", {b_rsp_valid, b_rsp_last, b_rsp_err, b_rsp_data}, {3'b110, exp_word(3)}); end
    step();
    checks++; if (b_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_b_once: got %b expected 0", b_rsp_valid); end
  endtask

  task automatic test_burst();
    logic [26:0] exp_t;
    drain();
    issue_req(5'd5, 3'd3);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        exp_t = {1'b1, (k == 3), 1'b0, exp_word(5 + k)};
        checks++; if ({a_rsp_valid, a_rsp_last, a_rsp_err, a_rsp_data} !== exp_t) begin errors++; $display("[TB] FAIL burst_a_word%0d: got %h expected %h", k, {a_rsp_valid, a_rsp_last, a_rsp_err, a_rsp_data}, exp_t); end
      end else begin
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL burst_a_end: got %b expected 0", a_rsp_valid); end
      end
      if (k == 0) begin
        checks++; if (a_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL burst_a_busy: got %b expected 0", a_req_ready); end
        checks++; if (b_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL burst_b_early: got %b expected 0", b_rsp_valid); end
      end else begin
        exp_t = {1'b1, (k == 4), 1'b0, exp_word(4 + k)};
        checks++; if ({b_rsp_valid, b_rsp_last, b_rsp_err, b_rsp_data} !== exp_t) begin errors++; $display("[TB] FAIL burst_b_word%0d: got %h expected %h", k - 1, {b_rsp_valid, b_rsp_last, b_rsp_err, b_rsp_data}, exp_t); end
      end
      if (k == 3) begin
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL burst_a_ready_after_last: got %b expected 1", a_req_ready); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic pat [4];
    int a_idx, b_idx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    drain();
    rsp_ready = pat[0];
    issue_req(5'd0, 3'd7);
    a_idx = 0;
    b_idx = 0;
    for (int c = 1; c < 60 && (a_idx < 8 || b_idx < 8); c++) begin
      rsp_ready = pat[c % 4];
      if (a_rsp_valid) begin
        checks++; if ({a_rsp_last, a_rsp_err, a_rsp_data} !== {(a_idx == 7), 1'b0, exp_word(a_idx)}) begin errors++; $display("[TB] FAIL bp_a_word%0d: got %h expected %h", a_idx, {a_rsp_last, a_rsp_err, a_rsp_data}, {(a_idx == 7), 1'b0, exp_word(a_idx)}); end
        if (a_idx <= 5) begin
          checks++; if (a_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_a_ready_early: got %b expected 0", a_req_ready); end
        end
        if (rsp_ready) a_idx++;
      end
      if (b_rsp_valid) begin
        checks++; if ({b_rsp_last, b_rsp_err, b_rsp_data} !== {(b_idx == 7), 1'b0, exp_word(b_idx)}) begin errors++; $display("[TB] FAIL bp_b_word%0d: got %h expected %h", b_idx, {b_rsp_last, b_rsp_err, b_rsp_data}, {(b_idx == 7), 1'b0, exp_word(b_idx)}); end
        if (b_idx <= 3) begin
          checks++; if (b_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_b_ready_early: got %b expected 0", b_req_ready); end
        end
        if (rsp_ready) b_idx++;
      end
      step();
    end
    checks++; if (a_idx !== 8) begin errors++; $display("[TB] FAIL bp_a_count: got %0d expected 8", a_idx); end
    checks++; if (b_idx !== 8) begin errors++; $display("[TB] FAIL bp_b_count: got %0d expected 8", b_idx); end
  endtask

  task automatic test_wrap_err();
    logic [26:0] exp_t;
    drain();
    issue_req(5'd29, 3'd2);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        exp_t = {1'b1, (k == 2), (k > 0), (k == 0) ? exp_word(29) : 24'h0};
        checks++; if ({a_rsp_valid, a_rsp_last, a_rsp_err, a_rsp_data} !== exp_t) begin errors++; $display("[TB] FAIL wrap_a_word%0d: got %h expected %h", k, {a_rsp_valid, a_rsp_last, a_rsp_err, a_rsp_data}, exp_t); end
      end else begin
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_a_end: got %b expected 0", a_rsp_valid); end
      end
      if (k > 0) begin
        exp_t = {1'b1, (k == 3), 1'b0, exp_word(28 + k)};
        checks++; if ({b_rsp_valid, b_rsp_last, b_rsp_err, b_rsp_data} !== exp_t) begin errors++; $display("[TB] FAIL wrap_b_word%0d: got %h expected %h", k - 1, {b_rsp_valid, b_rsp_last, b_rsp_err, b_rsp_data}, exp_t); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic seen;
    drain();
    issue_req(5'd0, 3'd7);
    step();
    step();
    checks++; if ({a_rsp_valid, a_rsp_last, a_rsp_err, a_rsp_data} !== {3'b100, exp_word(2)}) begin errors++; $display("[TB] FAIL rst_mid_a_third: got %h expected %h", {a_rsp_valid, a_rsp_last, a_rsp_err, a_rsp_data}, {3'b100, exp_word(2)}); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({a_req_ready, a_rsp_valid, a_rsp_data} !== 26'h0) begin errors++; $display("[TB] FAIL rst_mid_a_async: got %h expected %h", {a_req_ready, a_rsp_valid, a_rsp_data}, 26'h0); end
    checks++; if (b_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_b_async: got %b expected 0", b_rsp_valid); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if ({a_req_ready, b_req_ready} !== 2'b11) begin errors++; $display("[TB] FAIL rst_mid_ready: got %b expected 11", {a_req_ready, b_req_ready}); end
    seen = 1'b0;
    repeat (8) begin
      if (a_rsp_valid || b_rsp_valid) seen = 1'b1;
      step();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_stale: got %b expected 0", seen); end
    issue_req(5'd7, 3'd0);
    checks++; if ({a_rsp_valid, a_rsp_last, a_rsp_err, a_rsp_data} !== {3'b110, exp_word(7)}) begin errors++; $display("[TB] FAIL rst_mid_a_recover: got %h expected %h", {a_rsp_valid, a_rsp_last, a_rsp_err, a_rsp_data}, {3'b110, exp_word(7)}); end
    step();
    checks++; if ({b_rsp_valid, b_rsp_last, b_rsp_err, b_rsp_data} !== {3'b110, exp_word(7)}) begin errors++; $display("[TB] FAIL rst_mid_b_recover: got %h expected %h", {b_rsp_valid, b_rsp_last, b_rsp_err, b_rsp_data}, {3'b110, exp_word(7)}); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_wrap_err();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefetch_rom.md
PREFETCH_ROM -- requirements
Module: prefetch_rom

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, ROM word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 32, number of valid words; 1 <= DEPTH <= 2^ADDR_W.
REQ-004 The block SHALL have parameter LATENCY, default 1, cycles from read issue to data available; legal values 1 or 2.
REQ-005 The block SHALL have parameter LEN_W, default 3, burst length field width.
REQ-006 The block SHALL have parameter INIT_FILE, default "rom.txt", binary image loaded at elaboration.
REQ-007 The block SHALL have port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-009 The block SHALL have port req_valid, input, 1 bit, request present.
REQ-010 The block SHALL have port req_ready, output, 1 bit, request accepted when high with req_valid.
REQ-011 The block SHALL have port req_addr, input, ADDR_W bits, burst start address.
REQ-012 The block SHALL have port req_len, input, LEN_W bits, burst word count minus one.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit, response word present.
REQ-014 The block SHALL have port rsp_ready, input, 1 bit, consumer accepts word.
REQ-015 The block SHALL have port rsp_data, output, DATA_W bits, ROM word.
REQ-016 The block SHALL have port rsp_last, output, 1 bit, final word of burst.
REQ-017 The block SHALL have port rsp_err, output, 1 bit, word address was >= DEPTH.

Function
REQ-018 The block SHALL implement FSM states IDLE and BURST; req_ready SHALL be high only in IDLE.
REQ-019 On req_valid && req_ready, the block SHALL latch addr and remaining count = req_len, go to BURST, and issue the first read in that cycle.
REQ-020 In BURST, the block SHALL issue one read per cycle while response-buffer credit is available, incrementing addr modulo 2^ADDR_W.
REQ-021 After issuing the read with remaining count 0, the block SHALL return to IDLE; the next request can be accepted the cycle after.
REQ-022 Each issued read SHALL produce its word at rsp_data exactly LATENCY cycles later when the buffer is empty and rsp_ready is high.
REQ-023 Output buffering SHALL be a FIFO of LATENCY+1 entries; reads SHALL issue only if occupancy plus in-flight reads < LATENCY+1; no word SHALL be dropped or duplicated.
REQ-024 While rsp_valid && !rsp_ready, rsp_data, rsp_last and rsp_err SHALL stay stable.
REQ-025 With rsp_ready held high, the block SHALL sustain one word per cycle after the initial latency.
REQ-026 For an address >= DEPTH, rsp_data SHALL be 0 and rsp_err SHALL be 1; otherwise rsp_err SHALL be 0.
REQ-027 rsp_last SHALL be 1 only on the word issued with remaining count 0.
REQ-028 Address wrap-around from 2^ADDR_W-1 to 0 SHALL occur silently within a burst.
REQ-029 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged.

Reset
REQ-030 While rst_n=0, regardless of clk: state=IDLE, FIFO and in-flight reads cleared, rsp_valid=0, rsp_last=0, rsp_err=0, rsp_data=0, req_ready=0.
REQ-031 On the first rising clk edge after rst_n deasserts, req_ready SHALL be 1.
REQ-032 Reset asserted mid-burst SHALL abort the burst; no stale word SHALL appear after release.

Verification
REQ-033 Image word i = {3{3'b0,i}} (e.g. word 3 = 24'h030303); this image SHALL be used for all scenarios below.
REQ-034 Single read: req addr=3, len=0, rsp_ready=1, LATENCY=1 -> rsp_valid is 1 cycle later with data 24'h030303, last=1, err=0.
REQ-035 Burst of 4: addr=5, len=3, rsp_ready=1 -> 4 consecutive cycles with data 0x050505..0x080808, last on the 4th word only.
REQ-036 Backpressure: addr=0, len=7, rsp_ready toggled 1,0,0,1,... -> all 8 words 0x000000..0x070707 appear in order, data stable while stalled, req_ready=0 until the last issue.
REQ-037 Wrap/err: DEPTH=30, addr=29, len=2 -> words 0x1D1D1D (err=0), 0 (err=1, addr 30), 0 (err=1, addr 31).
REQ-038 Reset mid-burst: pull rst_n low during the third word of an 8-word burst -> rsp_valid=0 immediately; after release req_ready=1 and rsp_valid stays 0 until a new request.
REQ-039 LATENCY=2 sweep: rerun the single-read and burst scenarios -> first data 2 cycles after acceptance, then 1 word per cycle.
